// File: rtl/lstm_bp_sched_pkg.sv
// Shared types and helpers for the LSTM backprop timestep scheduler.
// State encoding is fixed so it can be matched against debug traces.
package lstm_bp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPUTE = 3'd1,
    S_PAUSE   = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  function automatic int max4(input int a, input int b,
                              input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lstm_bp_sched_dwell_cnt.sv
// Dwell counter shared by the COMPUTE, PAUSE and DRAIN phases.
// Counts up while enabled and wraps to 0 when it reaches last.
module sched_dwell_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

  // Next count: clear has priority, then wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tc ? '0 : cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lstm_bp_sched.sv
// Backprop timestep scheduler: walks timesteps downward, sweeping
// addresses with compute, writeback and drain phases per step.
module lstm_bp_sched
  import lstm_bp_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_ADDR   = 54,
  parameter int ROW_CYCLES = 53,
  parameter int PAUSE_LEN  = 4,
  parameter int DRAIN_LEN  = 3,
  parameter int NUM_STEPS  = 16,
  parameter int STEP_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [STEP_WIDTH-1:0] o_step,
  output logic                  o_mac_en,
  output logic                  o_acc_clr,
  output logic                  o_wr_en
);

  localparam int CW =
    $clog2(max4(ROW_CYCLES, PAUSE_LEN, DRAIN_LEN, 1)) + 1;
  localparam logic [ADDR_WIDTH-1:0] A_LAST =
    ADDR_WIDTH'(NUM_ADDR - 1);
  localparam logic [STEP_WIDTH-1:0] S_LAST =
    STEP_WIDTH'(NUM_STEPS - 1);
  localparam logic [CW-1:0] R_LAST = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PAUSE_LEN - 1);
  localparam logic [CW-1:0] D_LAST =
    (DRAIN_LEN > 0) ? CW'(DRAIN_LEN - 1) : '0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  step_end;
  logic [CW-1:0]         cnt, cnt_last;
  logic                  tc, cnt_clr, adv;

  assign adv     = ~stall;
  assign cnt_clr = (state_q == S_IDLE) || (state_q == S_DONE);

  // Terminal value for the phase currently dwelling.
  always_comb begin
    cnt_last = '0;
    case (state_q)
      S_COMPUTE: cnt_last = R_LAST;
      S_PAUSE:   cnt_last = P_LAST;
      S_DRAIN:   cnt_last = D_LAST;
      default:   cnt_last = '0;
    endcase
  end

  sched_dwell_cnt #(.W(CW)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (adv),
    .last (cnt_last),
    .cnt  (cnt),
    .tc   (tc)
  );

  // Next state, address and timestep.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    step_d   = step_q;
    step_end = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_COMPUTE;
        addr_d  = '0;
        step_d  = S_LAST;
      end
      S_COMPUTE: if (adv && tc) state_d = S_PAUSE;
      S_PAUSE: if (adv && tc) begin
        if (addr_q != A_LAST) begin
          state_d = S_COMPUTE;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end else if (DRAIN_LEN == 0) begin
          step_end = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (adv && tc) step_end = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (step_end) begin
      if (step_q != '0) begin
        state_d = S_COMPUTE;
        step_d  = step_q - STEP_WIDTH'(1);
        addr_d  = '0;
      end else begin
        state_d = S_DONE;
      end
    end
    busy_d = (state_d == S_COMPUTE) ||
             (state_d == S_PAUSE) ||
             (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // FSM and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_addr    = addr_q;
  assign o_step    = step_q;
  assign o_mac_en  = (state_q == S_COMPUTE) & ~stall;
  assign o_acc_clr = (state_q == S_COMPUTE) &
                     (cnt == '0) & ~stall;
  assign o_wr_en   = (state_q == S_PAUSE) &
                     (cnt == '0) & ~stall;

endmodule
